seq_rshifter16: RTL
===================

SEQ_RSHIFTER16 -- requirements
Module: seq_rshifter16

Interface
REQ-001: Parameter W, default 16, data width in bits.
REQ-002: Parameter NW, default 4, shift-amount width; 2^NW SHALL equal W.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: start  input  1  request to begin a shift; sampled only in IDLE.
REQ-006: AA  input  W  operand, captured on the edge that accepts start.
REQ-007: NN  input  NW  right-shift amount 0..W-1, captured with AA.
REQ-008: arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured with AA.
REQ-009: SSHO  output  W  shift result register.
REQ-010: busy  output  1  high while in SHIFT or DONE.
REQ-011: done  output  1  one-cycle pulse marking SSHO valid.

Function
REQ-012: The block SHALL be a multi-cycle right shifter that moves one bit position per clock, complementing the existing combinational left barrel shifter.
REQ-013: FSM states SHALL be IDLE, SHIFT and DONE, encoded in a registered state variable.
REQ-014: In IDLE with start=1: SSHO <= AA, count <= NN, mode <= arith; next state SHIFT if NN!=0, else DONE.
REQ-015: In IDLE with start=0: all registers SHALL hold.
REQ-016: In SHIFT, each edge SHALL shift SSHO right by one bit, fill MSB with 0 (logical) or SSHO[W-1] (arithmetic), and decrement count.
REQ-017: In SHIFT, when count==1 on the edge, next state SHALL be DONE. Otherwise the FSM SHALL remain in SHIFT.
REQ-018: In DONE, done=1 for exactly one cycle, SSHO SHALL hold, and next state SHALL be IDLE.
REQ-019: Latency: done SHALL be high in the cycle following the (NN+1)th rising edge after and including the edge that accepts start; SHIFT lasts exactly NN cycles.
REQ-020: start while busy=1 (SHIFT or DONE) SHALL be ignored; AA/NN/arith changes while busy SHALL NOT affect the result.
REQ-021: start in the same cycle the FSM returns to IDLE SHALL be accepted on the next edge; back-to-back operations need no extra idle cycle beyond DONE.
REQ-022: SSHO SHALL hold its last result in IDLE until the next accepted start.
REQ-023: Result SHALL equal AA >> NN (logical) or the sign-extended AA >>> NN (arithmetic); no wrap-around or rotation.
REQ-024: busy SHALL be a decode of state (SHIFT or DONE); done SHALL be a decode of state==DONE; both SHALL be glitch-free registered decodes.

Reset
REQ-025: With rst=1 on an edge: state <= IDLE, SSHO <= 0, count <= 0, mode <= 0, busy=0, done=0.
REQ-026: rst SHALL take priority over start and over any in-progress shift, aborting it with no done pulse.
REQ-027: After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-028: AA=0x8000, NN=15, arith=0, pulse start -> done after 16 edges, SSHO=0x0001, busy high for 16 cycles.
REQ-029: AA=0xB7BB, NN=4, arith=1 -> SSHO=0xFB7B. Same operands with arith=0 -> SSHO=0x0B7B. Both complete after 5 edges.
REQ-030: AA=0x5555, NN=0 -> done in the cycle after the accepting edge, SSHO=0x5555, no SHIFT cycles.
REQ-031: AA=16'd1038, NN=3, arith=0; apply start again with AA=0xFFFF, NN=1 at cycle 2 -> second start ignored, SSHO=0x0081 with a single done pulse.
REQ-032: AA=0xBFFF, NN=14, arith=1; assert rst at cycle 5 -> SSHO=0x0000, state IDLE, no done pulse. Then start AA=0x0015, NN=2 -> SSHO=0x0005.
REQ-033: Two operations separated only by DONE (start held high) -> both results correct and two distinct done pulses.

Source files
------------

// File: rtl/seq_rshifter16.sv
`default_nettype none
// ============================================================================
//  Module   : seq_rshifter16
//  Purpose  : Multi-cycle right shifter, one bit position per clock.
//             Logical (zero-fill) or arithmetic (sign-fill) mode, selected
//             when the operation is accepted. Result held in SSHO until the
//             next accepted start; done pulses for one cycle when it is valid.
//  Revision : 1.0  initial release
// ============================================================================
module seq_rshifter16 #(
   parameter int W  = 16,
   parameter int NW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  AA,
   input  logic [NW-1:0] NN,
   input  logic          arith,
   output logic [W-1:0]  SSHO,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  ssho_q,  ssho_d;
   logic [NW-1:0] count_q, count_d;
   logic          mode_q,  mode_d;
   logic          busy_q;
   logic          done_q;

   // Next-state and datapath update; every register holds unless its state acts on it.
   always_comb begin
      state_d = state_q;
      ssho_d  = ssho_q;
      count_d = count_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ssho_d  = AA;
               count_d = NN;
               mode_d  = arith;
               // A zero shift amount skips SHIFT and reports on the next cycle.
               state_d = (NN != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            // MSB fill comes from the current MSB in arithmetic mode, so the sign propagates.
            ssho_d  = {(mode_q & ssho_q[W-1]), ssho_q[W-1:1]};
            count_d = count_q - NW'(1);
            if (count_q == NW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; busy/done are registered decodes of the next state
   // so they change cleanly with the state and never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ssho_q  <= '0;
         count_q <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ssho_q  <= ssho_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign SSHO = ssho_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
`default_nettype wire
